// File: rtl/irq_wake_pkg.sv
// Shared types and helpers for the always-on interrupt controller / sleep sequencer.
package irq_wake_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SLEEP   = 2'd1,
    ST_WAKE    = 2'd2,
    ST_SERVICE = 2'd3
  } wake_state_t;

  // ID 0 is reserved to mean "no interrupt".
  localparam int ID_NONE = 0;

  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit synchroniser followed by a rising-edge detector for one interrupt source.
module irq_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/irq_wake_ctrl.sv
// Interrupt latch/arbiter plus RUN/SLEEP/WAKE/SERVICE sequencer driving the core's
// external interrupt line and clock-gate enable.
module irq_wake_ctrl
  import irq_wake_pkg::*;
#(
  parameter  int NUM_SRC     = 8,
  parameter  int PRIO_W      = 3,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = id_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        irq_src,
  input  logic [NUM_SRC-1:0]        irq_en,
  input  logic [NUM_SRC*PRIO_W-1:0] irq_prio,
  input  logic [PRIO_W-1:0]         prio_thresh,
  input  logic                      core_wfi,
  input  logic                      claim,
  input  logic                      complete,
  input  logic [ID_W-1:0]           complete_id,
  output logic                      ext_irq,
  output logic [ID_W-1:0]           claim_id,
  output logic                      core_clk_en,
  output logic                      cmpl_err
);

  localparam logic [ID_W-1:0] NO_ID = ID_W'(ID_NONE);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] clr_mask;

  logic [ID_W-1:0]    best_id_d;
  logic [ID_W-1:0]    best_id_q;
  logic [PRIO_W-1:0]  best_prio;

  wake_state_t        state_q;
  wake_state_t        state_d;
  logic               take_claim;
  logic               cmpl_ok;
  logic               cmpl_bad;

  logic [ID_W-1:0]    claim_id_q;
  logic [ID_W-1:0]    active_id_q;
  logic               cmpl_err_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(
      .STAGES (SYNC_STAGES)
    ) u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (irq_src[g]),
      .rise     (rise[g])
    );
  end

  // Highest priority wins; scanning upward with a strict compare keeps the
  // lowest index on ties.
  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    best_id_d = NO_ID;
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [PRIO_W-1:0] p;
      p = irq_prio[i*PRIO_W +: PRIO_W];
      if (pending_q[i] && irq_en[i] && (p > prio_thresh) && (p > best_prio)) begin
        best_prio = p;
        best_id_d = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    take_claim = 1'b0;
    cmpl_ok    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (claim) begin
          if (best_id_q != NO_ID) begin
            take_claim = 1'b1;
            state_d    = ST_SERVICE;
          end
        end else if (core_wfi && (best_id_q == NO_ID)) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (best_id_q != NO_ID) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        state_d = ST_RUN;
      end
      ST_SERVICE: begin
        if (complete && (complete_id == active_id_q)) begin
          cmpl_ok = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    cmpl_bad = complete && !cmpl_ok;
  end

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_mask[i] = take_claim && (best_id_q == ID_W'(i + 1));
    end
  end

  // A fresh edge on the bit being claimed in the same cycle is kept, not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      best_id_q   <= NO_ID;
      state_q     <= ST_RUN;
      claim_id_q  <= NO_ID;
      active_id_q <= NO_ID;
      cmpl_err_q  <= 1'b0;
    end else begin
      pending_q  <= (pending_q & ~clr_mask) | rise;
      best_id_q  <= best_id_d;
      state_q    <= state_d;
      cmpl_err_q <= cmpl_bad;
      if (claim) begin
        claim_id_q <= take_claim ? best_id_q : NO_ID;
      end
      if (take_claim) begin
        active_id_q <= best_id_q;
      end else if (cmpl_ok) begin
        active_id_q <= NO_ID;
      end
    end
  end

  assign ext_irq     = (best_id_q != NO_ID) && ((state_q == ST_RUN) || (state_q == ST_WAKE));
  assign core_clk_en = (state_q != ST_SLEEP);
  assign claim_id    = claim_id_q;
  assign cmpl_err    = cmpl_err_q;

endmodule

// File: tb/tb_irq_wake_ctrl.sv
// Directed bench for irq_wake_ctrl: latency, arbitration, sleep/wake, error and reset paths.
module tb_irq_wake_ctrl;
  import irq_wake_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int PRIO_W  = 3;
  localparam int ID_W    = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        irq_src;
  logic [NUM_SRC-1:0]        irq_en;
  logic [NUM_SRC*PRIO_W-1:0] irq_prio;
  logic [PRIO_W-1:0]         prio_thresh;
  logic                      core_wfi;
  logic                      claim;
  logic                      complete;
  logic [ID_W-1:0]           complete_id;
  logic                      ext_irq;
  logic [ID_W-1:0]           claim_id;
  logic                      core_clk_en;
  logic                      cmpl_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irq_wake_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .PRIO_W      (PRIO_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_src     (irq_src),
    .irq_en      (irq_en),
    .irq_prio    (irq_prio),
    .prio_thresh (prio_thresh),
    .core_wfi    (core_wfi),
    .claim       (claim),
    .complete    (complete),
    .complete_id (complete_id),
    .ext_irq     (ext_irq),
    .claim_id    (claim_id),
    .core_clk_en (core_clk_en),
    .cmpl_err    (cmpl_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int idx, input logic [PRIO_W-1:0] p);
    irq_prio[idx*PRIO_W +: PRIO_W] = p;
  endtask

  // Consumes the edge that samples the rising source.
  task automatic pulse_src(input logic [NUM_SRC-1:0] m);
    irq_src = m;
    tick();
    irq_src = '0;
  endtask

  task automatic do_claim(input string tag, input int exp_id);
    claim = 1'b1;
    tick();
    claim = 1'b0;
    check(tag, 32'(claim_id), 32'(exp_id));
  endtask

  task automatic do_complete(input int id);
    complete    = 1'b1;
    complete_id = ID_W'(id);
    tick();
    complete    = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    irq_src     = '0;
    irq_en      = '0;
    irq_prio    = '0;
    prio_thresh = '0;
    core_wfi    = 1'b0;
    claim       = 1'b0;
    complete    = 1'b0;
    complete_id = '0;

    // Reset / idle
    tick(4);
    check("rst_ext_irq", 32'(ext_irq), 32'd0);
    check("rst_clk_en", 32'(core_clk_en), 32'd1);
    check("rst_claim_id", 32'(claim_id), 32'd0);
    check("rst_cmpl_err", 32'(cmpl_err), 32'd0);
    tick(4);
    rst_n = 1'b1;
    tick(3);
    check("idle_ext_irq", 32'(ext_irq), 32'd0);
    check("idle_clk_en", 32'(core_clk_en), 32'd1);
    check("idle_claim_id", 32'(claim_id), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'(ST_RUN));

    // Single source: edge to ext_irq is 4 cycles
    irq_en = '1;
    set_prio(2, 3'd5);
    pulse_src(8'h04);
    tick(2);
    check("single_early", 32'(ext_irq), 32'd0);
    tick(1);
    check("single_ext_irq", 32'(ext_irq), 32'd1);
    do_claim("single_claim", 3);
    check("single_svc_irq", 32'(ext_irq), 32'd0);
    check("single_svc_state", 32'(dut.state_q), 32'(ST_SERVICE));
    do_complete(3);
    check("single_run_state", 32'(dut.state_q), 32'(ST_RUN));
    check("single_no_err", 32'(cmpl_err), 32'd0);
    tick();
    check("claim_id_hold", 32'(claim_id), 32'd3);

    // Priority and tie-break
    irq_prio = '0;
    set_prio(1, 3'd4);
    set_prio(5, 3'd4);
    set_prio(3, 3'd6);
    pulse_src(8'h2A);
    tick(3);
    check("prio_ext_irq", 32'(ext_irq), 32'd1);
    do_claim("prio_first", 4);
    do_complete(4);
    do_claim("prio_tie_low", 2);
    do_complete(2);
    do_claim("prio_tie_high", 6);
    do_complete(6);
    tick(2);
    check("prio_drained", 32'(ext_irq), 32'd0);

    // Threshold: prio == thresh is not eligible; lowering thresh acts next cycle
    irq_prio = '0;
    set_prio(3, 3'd2);
    prio_thresh = 3'd2;
    pulse_src(8'h08);
    tick(5);
    check("thresh_blocked", 32'(ext_irq), 32'd0);
    prio_thresh = 3'd1;
    tick();
    check("thresh_lowered", 32'(ext_irq), 32'd1);
    do_claim("thresh_claim", 4);
    do_complete(4);
    prio_thresh = '0;

    // Sleep / wake
    irq_prio = '0;
    set_prio(0, 3'd1);
    core_wfi = 1'b1;
    tick();
    check("sleep_clk_en", 32'(core_clk_en), 32'd0);
    check("sleep_state", 32'(dut.state_q), 32'(ST_SLEEP));
    core_wfi = 1'b0;
    pulse_src(8'h01);
    tick(2);
    check("sleep_hold", 32'(core_clk_en), 32'd0);
    tick();
    check("sleep_no_irq", 32'(ext_irq), 32'd0);
    tick();
    check("wake_state", 32'(dut.state_q), 32'(ST_WAKE));
    check("wake_clk_en", 32'(core_clk_en), 32'd1);
    check("wake_ext_irq", 32'(ext_irq), 32'd1);
    tick();
    check("wake_to_run", 32'(dut.state_q), 32'(ST_RUN));
    check("run_ext_irq", 32'(ext_irq), 32'd1);
    do_claim("wake_claim", 1);
    do_complete(1);

    // Error paths
    irq_prio = '0;
    set_prio(2, 3'd5);
    pulse_src(8'h04);
    tick(3);
    do_claim("err_claim", 3);
    core_wfi    = 1'b1;
    complete    = 1'b1;
    complete_id = 4'd7;
    tick();
    complete = 1'b0;
    check("err_mismatch", 32'(cmpl_err), 32'd1);
    check("err_stay_svc", 32'(dut.state_q), 32'(ST_SERVICE));
    tick();
    check("err_pulse_end", 32'(cmpl_err), 32'd0);
    check("svc_ignores_wfi", 32'(core_clk_en), 32'd1);
    core_wfi = 1'b0;
    do_claim("nested_claim", 0);
    do_complete(3);
    check("err_good_cmpl", 32'(cmpl_err), 32'd0);
    check("err_back_run", 32'(dut.state_q), 32'(ST_RUN));
    do_complete(3);
    check("err_run_cmpl", 32'(cmpl_err), 32'd1);
    check("err_run_state", 32'(dut.state_q), 32'(ST_RUN));

    // Mid-operation asynchronous reset
    irq_prio = '0;
    set_prio(2, 3'd5);
    set_prio(4, 3'd3);
    set_prio(6, 3'd3);
    pulse_src(8'h54);
    tick(3);
    do_claim("mid_claim", 3);
    check("mid_pending", 32'(dut.pending_q), 32'h50);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_claim_id", 32'(claim_id), 32'd0);
    check("mid_rst_ext_irq", 32'(ext_irq), 32'd0);
    check("mid_rst_clk_en", 32'(core_clk_en), 32'd1);
    check("mid_rst_state", 32'(dut.state_q), 32'(ST_RUN));
    check("mid_rst_pending", 32'(dut.pending_q), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("post_rst_quiet", 32'(ext_irq), 32'd0);
    pulse_src(8'h10);
    tick(3);
    check("post_rst_irq", 32'(ext_irq), 32'd1);
    do_claim("post_rst_claim", 5);
    do_complete(5);
    check("post_rst_done", 32'(dut.state_q), 32'(ST_RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_wake_ctrl.md
Name: irq_wake_ctrl

Overview:
Always-on interrupt controller and sleep sequencer in front of core_top.
- Synchronises and latches NUM_SRC asynchronous external interrupt sources.
- Arbitrates them by priority and drives the core's single external-interrupt line.
- Handles one claim/complete transaction at a time.
- Gates the core clock while the core sits in WFI, and wakes it when an eligible interrupt arrives.

Parameters:
NUM_SRC, 8, number of interrupt sources; IDs are 1..NUM_SRC, ID 0 means "none".
PRIO_W, 3, priority field width; priority 0 means never eligible.
SYNC_STAGES, 2, synchroniser flops per source (minimum 2).
ID_W, $clog2(NUM_SRC+1), width of the ID fields (derived, not overridable).

Ports:
clk  in  1  clock; driven from the always-on clock in the top level.
rst_n  in  1  reset; asynchronous, active-low.
irq_src  in  NUM_SRC  raw asynchronous interrupt levels; rising-edge triggered.
irq_en  in  NUM_SRC  per-source enable; quasi-static.
irq_prio  in  NUM_SRC*PRIO_W  per-source priority; source i occupies bits [i*PRIO_W +: PRIO_W].
prio_thresh  in  PRIO_W  a source is eligible only when prio > prio_thresh.
core_wfi  in  1  core is idle in WFI.
claim  in  1  single-cycle claim request from the core.
complete  in  1  single-cycle completion strobe.
complete_id  in  ID_W  ID being completed.
ext_irq  out  1  registered interrupt request to the core.
claim_id  out  ID_W  ID returned on claim; valid in the cycle after claim.
core_clk_en  out  1  core clock-gate enable.
cmpl_err  out  1  one-cycle pulse on an illegal completion.

Behaviour:
Reset values:
- ext_irq=0, claim_id=0, core_clk_en=1, cmpl_err=0.
- All pending bits clear, FSM in RUN.
- Reset is honoured mid-transaction: any claimed ID is dropped and pending bits are cleared.

Input capture:
- Each irq_src bit passes through SYNC_STAGES flops, then a rising-edge detector.
- A detected edge sets pending[i] one cycle later, even when irq_en[i]=0.
- pending[i] clears only when ID i+1 is claimed.
- A new edge arriving while pending[i] is already set is absorbed (no counting).
- Latency: irq_src rise to pending set = SYNC_STAGES+1 cycles; to ext_irq high = SYNC_STAGES+2 cycles.

Arbitration:
- Eligible set = pending & irq_en & (prio > prio_thresh).
- Winner = highest prio; ties go to the lowest index.
- best_id is registered every cycle (0 if nothing is eligible).
- ext_irq = (best_id != 0) and state is RUN or WAKE.

FSM states: RUN, SLEEP, WAKE, SERVICE.
- RUN (core_clk_en=1):
  - claim with best_id!=0: return claim_id=best_id next cycle, clear that pending bit, go to SERVICE.
  - claim with best_id==0: return claim_id=0, stay in RUN.
  - Otherwise, core_wfi=1 with nothing eligible: go to SLEEP.
  - Claim takes precedence over core_wfi when both occur in the same cycle.
- SLEEP: core_clk_en=0 from the first SLEEP cycle. When any source becomes eligible, go to WAKE.
- WAKE: core_clk_en=1 and ext_irq high. After exactly 1 cycle, go to RUN.
- SERVICE:
  - ext_irq=0; nested claims return 0.
  - Tracks the single outstanding ID.
  - complete with complete_id equal to the outstanding ID: go to RUN.
  - complete with a mismatched ID, or complete in any state other than SERVICE: cmpl_err pulses for 1 cycle, state unchanged.
  - core_wfi is ignored in SERVICE.
  - Edges arriving during SERVICE still set pending bits.

Other rules:
- claim_id holds its value until the next claim.
- Changes to irq_en, irq_prio or prio_thresh take effect on the next arbitration register update, i.e. 1 cycle later.

Decomposition:
- Package irq_wake_pkg holds:
  - the FSM state encoding (RUN=2'd0, SLEEP=2'd1, WAKE=2'd2, SERVICE=2'd3);
  - the ID_W function;
  - the ID_NONE constant (0).
- One sub-module, irq_sync_edge: a parameterised per-bit synchroniser plus rising-edge detector, instantiated with a generate loop over NUM_SRC.
- Arbitration and the FSM live in the top module.

Test Plan:
1. Reset/idle: hold rst_n=0 for 8 cycles, then release with all inputs 0 -> ext_irq=0, core_clk_en=1, claim_id=0, cmpl_err=0 throughout.
2. Single source: all en=1, prio[2]=5, thresh=0; pulse irq_src[2] -> ext_irq rises 4 cycles after the edge. Claim -> claim_id=3 next cycle, ext_irq=0. complete_id=3 -> back in RUN.
3. Priority and tie: sources 1 and 5 at prio 4, source 3 at prio 6, all edges in the same cycle -> successive claims return 4, then 2, then 6. Source 3 at prio 2 with thresh=2 is never presented.
4. Sleep/wake: core_wfi=1 with nothing pending -> core_clk_en=0 the next cycle. Edge on source 0 (prio 1, thresh 0) -> WAKE with core_clk_en=1 and ext_irq=1, then RUN.
5. Error paths: complete_id=7 while 3 is outstanding -> cmpl_err pulses once, state stays SERVICE. complete in RUN -> cmpl_err pulses. A claim during SERVICE -> claim_id=0.
6. Mid-operation reset: assert rst_n=0 asynchronously during SERVICE with 2 bits pending -> outputs take their reset values immediately. After release, ext_irq=0 until a new edge.
